seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Memory-mapped eight-digit seven-segment display controller. It sits directly downstream of the store-address decoder and consumes the seven-segment write strobe issued for word stores to peripheral address 0x804. It captures the 32-bit store data and shows it as eight hexadecimal digits. The digits are time-multiplexed onto shared active-low cathode and anode lines using a free-running scan counter.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles each digit stays selected; legal range 2..2^20.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- we  in  1  write strobe from the store-address decoder, asserted for a store to 0x804.
- wdata  in  32  store data; sampled when we=1.
- rdata  out  32  current contents of the display register, for debug readback.
- an  out  8  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  8  segment cathodes, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

## Operation
- The display register (32 bits) loads wdata on any edge with we=1 and rst=0.
  - Otherwise it holds.
  - rdata is the register itself (no extra delay).
- Digit k (k=0..7) shows nibble value[4k+3:4k].
- The divider counter div has width ceil(log2(SCAN_DIV)) and resets to 0.
  - Each edge: if div==SCAN_DIV-1, div←0 and idx←idx+1 (3-bit, 7 wraps to 0).
  - Otherwise div←div+1.
- The digit index idx resets to 0.
- Scanning is free-running. Writes never reset or stall div or idx.
- an and seg are registered outputs:
  - an ← ~(8'b1 << idx).
  - seg ← {1'b1, hexcode(value[4*idx+3 -: 4])}, using the current idx and register value.
- Decimal point is always off (seg[7]=1).
- hexcode, shown as full 8-bit seg values:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Exactly one anode is low at any time after the first post-reset edge. No blanking gap between digits.

## Timing
Reset values (edge with rst=1):
- value=0, rdata=0, div=0, idx=0.
- an=8'hFF and seg=8'hFF (all dark).
- rst has priority over we on the same edge.

Latency:
- A write on edge N makes rdata show the new value after edge N.
- an/seg reflect the new value from edge N+1 on, whenever the affected digit is selected.
- an/seg always lag idx/value by exactly one cycle.

Dwell and refresh:
- Each idx value lasts SCAN_DIV cycles.
- A full refresh takes 8*SCAN_DIV cycles.

First frame after reset:
- The first edge with rst=0 drives an=FE and seg=hexcode(value[3:0]).
- That state lasts SCAN_DIV cycles. After that, an=FD.

Simultaneous write and digit advance (we=1 on the edge where div wraps):
- value and idx both update on that edge.
- The next edge outputs the new digit with the new data.

Back-to-back writes on consecutive edges:
- Each write is accepted.
- Last write wins.

Reset mid-scan:
- All state returns to reset values on that edge.
- The scan restarts at digit 0 with a full SCAN_DIV dwell.

## Test plan
(All scenarios use SCAN_DIV=4.)
- Reset check:
  - Stimulus: hold rst 2 cycles, release.
  - Response: during reset an=FF, seg=FF, rdata=0. First edge after release an=FE, seg=C0. an=FE holds 4 cycles, then FD.
- Write and scan:
  - Stimulus: we=1, wdata=32'h89AB_CDEF, then run one frame (32 cycles).
  - Response: rdata=89ABCDEF next cycle.
  - Anode/segment sequence FE/8E, FD/86, FB/A1, F7/C6, EF/83, DF/88, BF/90, 7F/80, 4 cycles each, then FE repeats.
- All-digit decode:
  - Stimulus: write 32'h7654_3210, then 32'hFEDC_BA98.
  - Response: all 16 hexcode values appear on seg at the matching anodes.
- Collision and last-wins:
  - Stimulus: write 32'h1 on the edge where div wraps from 3 to 0 while idx goes 7→0. Then write 32'h2 and 32'h3 on consecutive edges.
  - Response: next edge an=FE, seg=F9. After the pair, rdata=3 and seg=B0 while an=FE.
- Reset priority and mid-scan reset:
  - Stimulus: assert rst together with we=1, wdata=32'hFFFF_FFFF while idx=5.
  - Response: rdata=0, an=FF. After release, scan restarts at an=FE, seg=C0.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Store-side bus for the seven-segment display register: write strobe, store data
// and debug readback of the captured word.
interface seg7_scan_ctrl_if;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit hex display controller: latches a 32-bit word from the store bus and
// time-multiplexes its nibbles onto shared active-low anode/cathode lines.
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_ctrl_if.slave       bus,
    output logic [7:0]            an,
    output logic [7:0]            seg
);
    localparam int unsigned     DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [31:0]      value_q, value_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       nib;

    // Low seven cathode bits (g..a), active-low; the dp bit is prepended separately.
    function automatic logic [6:0] hexcode(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h40;
            4'h1: c = 7'h79;
            4'h2: c = 7'h24;
            4'h3: c = 7'h30;
            4'h4: c = 7'h19;
            4'h5: c = 7'h12;
            4'h6: c = 7'h02;
            4'h7: c = 7'h78;
            4'h8: c = 7'h00;
            4'h9: c = 7'h10;
            4'hA: c = 7'h08;
            4'hB: c = 7'h03;
            4'hC: c = 7'h46;
            4'hD: c = 7'h21;
            4'hE: c = 7'h06;
            default: c = 7'h0E;
        endcase
        return c;
    endfunction

    always_comb begin
        value_d = bus.we ? bus.wdata : value_q;
        div_d   = div_q + DIV_W'(1);
        idx_d   = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
        // Outputs are built from the pre-edge idx/value, so they trail them by one cycle.
        nib   = value_q[{idx_q, 2'b00} +: 4];
        an_d  = ~(8'b0000_0001 << idx_q);
        seg_d = {1'b1, hexcode(nib)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            value_q <= value_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.rdata = value_q;
    assign an        = an_q;
    assign seg       = seg_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4: reset, full-frame scans,
// all-digit decode, write/wrap collision, last-write-wins and mid-scan reset.
module tb_seg7_scan_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] an;
    logic [7:0] seg;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .an  (an),
        .seg (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [31:0] wdata;
        logic [7:0]  an;
        logic [7:0]  seg;
        logic [31:0] rdata;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  hex_tab [16];
    logic [31:0] words [3];

    task automatic step(input logic r, input logic w, input logic [31:0] d);
        rst       = r;
        bus.we    = w;
        bus.wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] e_an,
                         input logic [7:0] e_seg, input logic [31:0] e_rd);
        n_cmp++;
        if ({an, seg, bus.rdata} !== {e_an, e_seg, e_rd}) begin
            n_bad++;
            $display("FAIL %s: got an=%h seg=%h rdata=%h, required an=%h seg=%h rdata=%h",
                     name, an, seg, bus.rdata, e_an, e_seg, e_rd);
        end
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] w;
        logic [7:0]  an_e;
        logic [3:0]  nib;

        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        words   = '{32'h89AB_CDEF, 32'h7654_3210, 32'hFEDC_BA98};

        // Each block: write on the digit-7 -> digit-0 wrap edge, then 31 scan edges.
        prev = 32'h0;
        for (int k = 0; k < 3; k++) begin
            w = words[k];
            tbl.push_back('{1'b1, w, 8'h7F, hex_tab[prev[31:28]], w});
            for (int j = 1; j < 32; j++) begin
                int d;
                d    = (j - 1) / 4;
                an_e = ~(8'h01 << d);
                nib  = w[4*d +: 4];
                tbl.push_back('{1'b0, 32'h0, an_e, hex_tab[nib], w});
            end
            prev = w;
        end
        tbl.push_back('{1'b0, 32'h0, 8'h7F, hex_tab[prev[31:28]], prev});

        rst       = 1'b1;
        bus.we    = 1'b0;
        bus.wdata = 32'h0;

        step(1'b1, 1'b0, 32'h0);
        check("reset_edge1", 8'hFF, 8'hFF, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("reset_edge2", 8'hFF, 8'hFF, 32'h0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check("first_dwell", 8'hFE, 8'hC0, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0);
        check("first_advance", 8'hFD, 8'hC0, 32'h0);

        repeat (26) step(1'b0, 1'b0, 32'h0);

        foreach (tbl[i]) begin
            step(1'b0, tbl[i].we, tbl[i].wdata);
            check($sformatf("table[%0d]", i), tbl[i].an, tbl[i].seg, tbl[i].rdata);
        end

        repeat (31) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h1);
        check("collision_edge", 8'h7F, 8'h8E, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        check("collision_next", 8'hFE, 8'hF9, 32'h1);
        step(1'b0, 1'b1, 32'h2);
        check("b2b_write2", 8'hFE, 8'hF9, 32'h2);
        step(1'b0, 1'b1, 32'h3);
        check("b2b_write3", 8'hFE, 8'hA4, 32'h3);
        step(1'b0, 1'b0, 32'h0);
        check("last_wins", 8'hFE, 8'hB0, 32'h3);

        // Park at digit 5, then reset with a competing write.
        repeat (16) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        check("rst_priority", 8'hFF, 8'hFF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check("restart_dwell", 8'hFE, 8'hC0, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0);
        check("restart_advance", 8'hFD, 8'hC0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
